// File: rtl/gpr_dump_reader.sv
// Walks a GPR read port one index at a time and streams {index, value} beats
// over valid/ready, keeping a running wrap-around checksum of accepted beats.
module gpr_dump_reader #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter bit SKIP_X0  = 1'b0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] gpr_rd_addr,
    input  logic [DATA_W-1:0] gpr_rd_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_last,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_SEND = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam logic [ADDR_W-1:0] FIRST_ADDR = SKIP_X0 ? ADDR_W'(1) : ADDR_W'(0);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_REGS - 1);
    // With x0 skipped and only one register there is nothing to emit.
    localparam bit EMPTY_DUMP = SKIP_X0 && (NUM_REGS == 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_q, last_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] csum_q, csum_d;

    // Next-state and datapath update for the dump walk.
    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        valid_d   = valid_q;
        addr_d    = addr_q;
        data_d    = data_q;
        last_d    = last_q;
        done_d    = 1'b0;
        csum_d    = csum_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rd_addr_d = FIRST_ADDR;
                    csum_d    = DATA_W'(0);
                    state_d   = EMPTY_DUMP ? S_DONE : S_READ;
                    done_d    = EMPTY_DUMP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                if (abort) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end else begin
                    addr_d  = rd_addr_q;
                    data_d  = gpr_rd_data;
                    last_d  = (rd_addr_q == LAST_ADDR);
                    valid_d = 1'b1;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                // Abort outranks the handshake, so a beat aborted mid-accept is not summed.
                if (abort) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end else if (dump_ready) begin
                    csum_d  = csum_q + data_q;
                    valid_d = 1'b0;
                    if (last_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        rd_addr_d = rd_addr_q + ADDR_W'(1);
                        state_d   = S_READ;
                    end
                end else begin
                    state_d = S_SEND;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            rd_addr_q <= ADDR_W'(0);
            valid_q   <= 1'b0;
            addr_q    <= ADDR_W'(0);
            data_q    <= DATA_W'(0);
            last_q    <= 1'b0;
            done_q    <= 1'b0;
            csum_q    <= DATA_W'(0);
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            valid_q   <= valid_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            last_q    <= last_d;
            done_q    <= done_d;
            csum_q    <= csum_d;
        end
    end

    assign gpr_rd_addr = rd_addr_q;
    assign dump_valid  = valid_q;
    assign dump_addr   = addr_q;
    assign dump_data   = data_q;
    assign dump_last   = last_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign checksum    = csum_q;

endmodule

// File: tb/tb_gpr_dump_reader.sv
// Scoreboard bench for gpr_dump_reader: a GPR array model feeds the read port,
// expected beats are queued at start and popped on each handshake.
module tb_gpr_dump_reader;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start, start_s, abort, ready;
    logic [4:0]  rd_addr, rd_addr_s, daddr, daddr_s;
    logic [31:0] rd_data, rd_data_s, ddata, ddata_s, csum, csum_s;
    logic        valid, valid_s, last, last_s, busy, busy_s, done, done_s;

    logic [31:0] gpr [32];
    logic [36:0] exp_q [$];
    int          tests_run = 0;
    int          tests_failed = 0;

    localparam logic [31:0] FULL_SUM  = 32'h8000_1FEE;
    localparam logic [31:0] ABORT_SUM = 32'h8000_0308;

    always #5 clk = ~clk;

    assign rd_data   = gpr[rd_addr];
    assign rd_data_s = gpr[rd_addr_s];

    gpr_dump_reader #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .SKIP_X0(1'b0)) dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort),
        .gpr_rd_addr(rd_addr), .gpr_rd_data(rd_data),
        .dump_valid(valid), .dump_ready(ready), .dump_addr(daddr), .dump_data(ddata),
        .dump_last(last), .busy(busy), .done(done), .checksum(csum)
    );

    gpr_dump_reader #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .SKIP_X0(1'b1)) dut_s (
        .clk(clk), .rstn(rstn), .start(start_s), .abort(abort),
        .gpr_rd_addr(rd_addr_s), .gpr_rd_data(rd_data_s),
        .dump_valid(valid_s), .dump_ready(ready), .dump_addr(daddr_s), .dump_data(ddata_s),
        .dump_last(last_s), .busy(busy_s), .done(done_s), .checksum(csum_s)
    );

    task automatic push_expected(input int first);
        exp_q.delete();
        for (int i = first; i < 32; i++) exp_q.push_back({i[4:0], gpr[i]});
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 1'b0; start_s = 1'b0; abort = 1'b0; ready = 1'b0;
        #1;
        tests_run++;
        if ({rd_addr, valid, daddr, ddata, last, busy, done, csum} !== 76'd0) begin
            tests_failed++;
            $display("FAIL reset_values: got %h want 0", {rd_addr, valid, daddr, ddata, last, busy, done, csum});
        end
        @(negedge clk); @(negedge clk); rstn = 1'b1; @(negedge clk);
    endtask

    task automatic test_full();
        int k, beats, dones; logic [36:0] e;
        push_expected(0);
        ready = 1'b1; start = 1'b1; @(negedge clk); start = 1'b0;
        k = 1; beats = 0; dones = 0;
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("FAIL full_busy: got %b want 1", busy); end
        while (k < 120 && dones == 0) begin
            if (k == 2) begin
                tests_run++;
                if (valid !== 1'b1) begin tests_failed++; $display("FAIL full_first_valid_latency: got %b want 1", valid); end
            end
            if (valid && ready) begin
                beats++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 37'h1f_ffff_ffff;
                tests_run++;
                if ({daddr, ddata} !== e || last !== (e[36:32] == 5'd31)) begin
                    tests_failed++;
                    $display("FAIL full_beat: got addr %0d data %h last %b want %0d %h", daddr, ddata, last, e[36:32], e[31:0]);
                end
            end
            if (done) begin
                dones++;
                tests_run++;
                if (k != 65) begin tests_failed++; $display("FAIL full_done_cycle: got %0d want 65", k); end
            end
            @(negedge clk); k++;
        end
        tests_run++;
        if (beats != 32 || dones != 1) begin tests_failed++; $display("FAIL full_counts: got beats %0d dones %0d want 32 1", beats, dones); end
        tests_run++;
        if (csum !== FULL_SUM) begin tests_failed++; $display("FAIL full_checksum: got %h want %h", csum, FULL_SUM); end
    endtask

    task automatic test_backpressure();
        int k, beats, dones; logic [36:0] e;
        logic pv, pr; logic [4:0] pa; logic [31:0] pd;
        push_expected(0);
        ready = 1'b0; start = 1'b1; @(negedge clk); start = 1'b0;
        k = 1; beats = 0; dones = 0; pv = 1'b0; pr = 1'b0; pa = 5'd0; pd = 32'd0;
        while (k < 600 && dones == 0) begin
            ready = ($urandom_range(0, 1) == 1);
            if (pv && !pr) begin
                tests_run++;
                if (valid !== 1'b1 || daddr !== pa || ddata !== pd) begin
                    tests_failed++;
                    $display("FAIL bp_stable: got v%b %0d %h want v1 %0d %h", valid, daddr, ddata, pa, pd);
                end
            end
            if (valid && ready) begin
                beats++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 37'h1f_ffff_ffff;
                tests_run++;
                if ({daddr, ddata} !== e) begin
                    tests_failed++;
                    $display("FAIL bp_beat: got %0d %h want %0d %h", daddr, ddata, e[36:32], e[31:0]);
                end
            end
            if (done) dones++;
            pv = valid; pr = ready; pa = daddr; pd = ddata;
            @(negedge clk); k++;
        end
        tests_run++;
        if (beats != 32 || dones != 1 || csum !== FULL_SUM) begin
            tests_failed++;
            $display("FAIL bp_totals: got beats %0d dones %0d sum %h want 32 1 %h", beats, dones, csum, FULL_SUM);
        end
        ready = 1'b1; @(negedge clk);
    endtask

    task automatic test_start_while_busy();
        int k, beats, dones;
        ready = 1'b1; start = 1'b1; @(negedge clk); start = 1'b0;
        k = 1; beats = 0; dones = 0;
        while (k < 100) begin
            start = (k == 10);
            if (valid && ready) beats++;
            if (done) dones++;
            @(negedge clk); k++;
        end
        start = 1'b0;
        tests_run++;
        if (beats != 32 || dones != 1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL restart_ignored: got beats %0d dones %0d busy %b want 32 1 0", beats, dones, busy);
        end
    endtask

    task automatic test_abort();
        int k; bit hit;
        ready = 1'b1; start = 1'b1; @(negedge clk); start = 1'b0;
        k = 1; hit = 1'b0;
        while (k < 60 && !hit) begin
            if (valid && daddr == 5'd5) begin abort = 1'b1; hit = 1'b1; end
            else begin @(negedge clk); k++; end
        end
        @(negedge clk); abort = 1'b0;
        tests_run++;
        if (!hit || valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_stop: got hit %b valid %b busy %b done %b want 1 0 0 0", hit, valid, busy, done);
        end
        tests_run++;
        if (csum !== ABORT_SUM) begin tests_failed++; $display("FAIL abort_checksum: got %h want %h", csum, ABORT_SUM); end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (done !== 1'b0 || valid !== 1'b0) begin tests_failed++; $display("FAIL abort_quiet: got done %b valid %b want 0 0", done, valid); end
            @(negedge clk);
        end
        // start and abort together in IDLE: start wins
        start = 1'b1; abort = 1'b1; @(negedge clk); start = 1'b0;
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("FAIL start_beats_abort: got busy %b want 1", busy); end
        @(negedge clk); abort = 1'b0;
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL abort_in_read: got busy %b want 0", busy); end
    endtask

    task automatic test_skip_x0();
        int k, beats, dones; logic [36:0] e;
        push_expected(1);
        ready = 1'b1; start_s = 1'b1; @(negedge clk); start_s = 1'b0;
        k = 1; beats = 0; dones = 0;
        while (k < 120 && dones == 0) begin
            if (valid_s && ready) begin
                beats++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 37'h1f_ffff_ffff;
                tests_run++;
                if ({daddr_s, ddata_s} !== e) begin
                    tests_failed++;
                    $display("FAIL skip_beat: got %0d %h want %0d %h", daddr_s, ddata_s, e[36:32], e[31:0]);
                end
            end
            if (done_s) dones++;
            @(negedge clk); k++;
        end
        tests_run++;
        if (beats != 31 || dones != 1 || csum_s !== FULL_SUM) begin
            tests_failed++;
            $display("FAIL skip_totals: got beats %0d dones %0d sum %h want 31 1 %h", beats, dones, csum_s, FULL_SUM);
        end
    endtask

    task automatic test_reset_mid_dump();
        ready = 1'b1; start = 1'b1; @(negedge clk); start = 1'b0;
        repeat (20) @(negedge clk);
        rstn = 1'b0; #1;
        tests_run++;
        if ({rd_addr, valid, daddr, ddata, last, busy, done, csum} !== 76'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_dump: got %h want 0", {rd_addr, valid, daddr, ddata, last, busy, done, csum});
        end
        @(negedge clk); rstn = 1'b1; @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0; @(negedge clk);
        tests_run++;
        if (valid !== 1'b1 || daddr !== 5'd0 || ddata !== gpr[0]) begin
            tests_failed++;
            $display("FAIL restart_from_zero: got v%b %0d %h want v1 0 %h", valid, daddr, ddata, gpr[0]);
        end
        abort = 1'b1; @(negedge clk); abort = 1'b0; @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) gpr[i] = (i == 0) ? 32'd0 : 32'h100 + i;
        gpr[2] = 32'h8000_0000;
        test_reset();
        test_full();
        test_backpressure();
        test_start_while_busy();
        test_abort();
        test_skip_x0();
        test_reset_mid_dump();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
